control_unit_fsm: RTL
=====================

// Module: control_unit_fsm
// PURPOSE
// Instruction sequencer for the 16-bit datapath: latches a 9-bit instruction from DIN,
// then steps T0..T3 driving the bus multiplexer selects (selectR/selectG/selectDin),
// register/A/G load enables and the ALU op. Sits directly upstream of the bus multiplexer.
// Outputs are decoded combinationally from the step counter and IR.
// PARAMETERS
// DATA_WIDTH  16  width of DIN; IR is always DIN[8:0]
// PORTS
// Clock      in   1            rising-edge clock
// Reset      in   1            asynchronous, active-high reset
// Run        in   1            start: sampled only in T0
// DIN        in   DATA_WIDTH   instruction/immediate bus from memory
// gNonZero   in   1            G register != 0 (for mvnz)
// selectR    out  8            one-hot bus source; bit7=R0 ... bit0=R7; 0 = none
// selectG    out  1            drive G onto bus
// selectDin  out  1            drive DIN onto bus
// Rin        out  8            register write enables, same bit order as selectR
// Ain        out  1            load A from bus
// Gin        out  1            load G from ALU
// IRin       out  1            IR load strobe (debug/observe)
// aluOp      out  2            00 add, 01 sub, 10 and, 11 slt (signed A<bus ? 1:0)
// Done       out  1            final step of the current instruction
// step       out  2            current Tstep (0..3)
// BEHAVIOUR
// - IR = {III, XXX, YYY} = DIN[8:6], DIN[5:3], DIN[2:0]; X/Y select R0..R7 (R0 -> bit7).
// - Reset high: step=T0, IR=0 immediately; all outputs forced 0 while Reset high.
// - Default each cycle: all outputs 0 except as listed; selectR, selectG, selectDin mutually exclusive.
// - T0: IRin=Run; if Run, IR<=DIN[8:0] and step->T1; else stay T0. Run outside T0 ignored.
// - 000 mv:   T1 selectR=Y, Rin=X, Done.
// - 001 mvi:  T1 selectDin=1, Rin=X, Done (DIN holds immediate this cycle).
// - 010 add / 011 sub / 100 and / 101 slt (aluOp = 00/01/10/11):
//     T1 selectR=X, Ain; T2 selectR=Y, Gin, aluOp valid; T3 selectG, Rin=X, Done.
// - 110 mvnz: T1 if gNonZero {selectR=Y, Rin=X}; Done regardless.
// - 111 reserved: T1 Done only, no enables (NOP).
// - aluOp is 00 in every step except T2 of an ALU instruction.
// - Step after Done is always T0; step never exceeds T3; no wrap without Done.
// - Latency: mv/mvi/mvnz/nop 2 cycles incl. T0, ALU ops 4 cycles.
// - Run held high continuously: next instruction latched in the T0 following Done
//   (no idle cycle beyond T0).
// - X==Y legal (e.g. add R3,R3): same select in T1 and T2.
// - Reset mid-instruction: abort, no further Rin/Gin pulses, resume T0 after release.
// TESTING
// - Reset asserted in T2 of add -> step=0 same cycle, all outputs 0, IR=0.
// - Run=1, DIN=9'b001_010_000 (mvi R2) -> T1: selectDin=1, Rin=8'b00100000, Done=1; T0 next cycle.
// - DIN=9'b010_001_011 (add R1,R3) -> T1 selectR=0x40, Ain; T2 selectR=0x10, Gin,
//   aluOp=00; T3 selectG, Rin=0x40, Done.
// - mvnz R0,R7 with gNonZero=0 -> T1 Done=1, Rin=0, selectR=0; with gNonZero=1 -> selectR=0x01, Rin=0x80.
// - Run pulsed during T2 of sub with new DIN -> IR unchanged, sequence completes normally.
// - Run held high, mv then slt back-to-back -> exactly one T0 between them; slt T2 aluOp=11.

Source files
------------

// File: rtl/control_unit_fsm.sv
// control_unit_fsm
//   Instruction sequencer for the 16-bit datapath. In T0 it latches a 9-bit
//   instruction {III,XXX,YYY} from DIN when Run is high. It then steps through
//   T1..T3 and drives the bus-source selects, the load enables and the ALU op
//   for that instruction. All outputs are decoded combinationally from the
//   step counter, the instruction register and the live inputs. Every output
//   is held at 0 while Reset_i is high.
//
// Ports
//   Clock_i      in   1           rising-edge clock
//   Reset_i      in   1           asynchronous, active-high reset
//   Run_i        in   1           start strobe, sampled only in T0
//   DIN_i        in   DATA_WIDTH  instruction / immediate bus (IR = DIN[8:0])
//   gNonZero_i   in   1           G register != 0 (condition for mvnz)
//   selectR_o    out  8           one-hot bus source, bit7=R0 .. bit0=R7
//   selectG_o    out  1           drive G onto bus
//   selectDin_o  out  1           drive DIN onto bus
//   Rin_o        out  8           register write enables (same order as selectR)
//   Ain_o        out  1           load A from bus
//   Gin_o        out  1           load G from ALU
//   IRin_o       out  1           IR load strobe
//   aluOp_o      out  2           00 add, 01 sub, 10 and, 11 slt
//   Done_o       out  1           final step of the current instruction
//   step_o       out  2           current time step (0..3)
module control_unit_fsm #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  Clock_i,
  input  logic                  Reset_i,
  input  logic                  Run_i,
  input  logic [DATA_WIDTH-1:0] DIN_i,
  input  logic                  gNonZero_i,
  output logic [7:0]            selectR_o,
  output logic                  selectG_o,
  output logic                  selectDin_o,
  output logic [7:0]            Rin_o,
  output logic                  Ain_o,
  output logic                  Gin_o,
  output logic                  IRin_o,
  output logic [1:0]            aluOp_o,
  output logic                  Done_o,
  output logic [1:0]            step_o
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_e;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_MVNZ = 3'b110;

  step_e      step_q, step_d;
  logic [8:0] ir_q, ir_d;

  logic [2:0] op;
  logic [2:0] rx;
  logic [2:0] ry;
  logic       is_alu;

  // Only the low 9 bits of DIN carry an instruction; the rest is immediate data
  // that reaches the registers through the bus, not through this block.
  logic unused_din_hi;
  assign unused_din_hi = ^DIN_i[DATA_WIDTH-1:9];

  assign op     = ir_q[8:6];
  assign rx     = ir_q[5:3];
  assign ry     = ir_q[2:0];
  assign is_alu = (op >= 3'b010) && (op <= 3'b101);

  // Register index 0 maps to bit 7, so the one-hot is a right shift of the MSB.
  function automatic logic [7:0] reg_onehot(input logic [2:0] idx);
    return 8'h80 >> idx;
  endfunction

  always_ff @(posedge Clock_i or posedge Reset_i) begin
    if (Reset_i) begin
      step_q <= T0;
      ir_q   <= 9'd0;
    end else begin
      step_q <= step_d;
      ir_q   <= ir_d;
    end
  end

  always_comb begin
    step_d      = step_q;
    ir_d        = ir_q;
    selectR_o   = 8'h00;
    selectG_o   = 1'b0;
    selectDin_o = 1'b0;
    Rin_o       = 8'h00;
    Ain_o       = 1'b0;
    Gin_o       = 1'b0;
    IRin_o      = 1'b0;
    aluOp_o     = 2'b00;
    Done_o      = 1'b0;

    unique case (step_q)
      T0: begin
        IRin_o = Run_i;
        if (Run_i) begin
          ir_d   = DIN_i[8:0];
          step_d = T1;
        end
      end

      T1: begin
        step_d = T0;
        if (is_alu) begin
          selectR_o = reg_onehot(rx);
          Ain_o     = 1'b1;
          step_d    = T2;
        end else begin
          // mv, mvi, mvnz and the reserved opcode all finish in T1.
          Done_o = 1'b1;
          if (op == OP_MV || (op == OP_MVNZ && gNonZero_i)) begin
            selectR_o = reg_onehot(ry);
            Rin_o     = reg_onehot(rx);
          end else if (op == OP_MVI) begin
            selectDin_o = 1'b1;
            Rin_o       = reg_onehot(rx);
          end
        end
      end

      T2: begin
        step_d = T0;
        if (is_alu) begin
          selectR_o = reg_onehot(ry);
          Gin_o     = 1'b1;
          // 010/011/100/101 -> 00/01/10/11 is simply {op[2], op[0]}.
          aluOp_o   = {op[2], op[0]};
          step_d    = T3;
        end
      end

      T3: begin
        step_d = T0;
        if (is_alu) begin
          selectG_o = 1'b1;
          Rin_o     = reg_onehot(rx);
          Done_o    = 1'b1;
        end
      end

      default: step_d = T0;
    endcase

    // Outputs are silenced for the whole reset assertion, not only after the
    // state register has cleared.
    if (Reset_i) begin
      selectR_o   = 8'h00;
      selectG_o   = 1'b0;
      selectDin_o = 1'b0;
      Rin_o       = 8'h00;
      Ain_o       = 1'b0;
      Gin_o       = 1'b0;
      IRin_o      = 1'b0;
      aluOp_o     = 2'b00;
      Done_o      = 1'b0;
    end
  end

  assign step_o = step_q;

endmodule
